// File: rtl/alu_bist_seq_if.sv
// alu_bist_seq_if: operand/function/result/flag bundle between the ALU
// self-test sequencer (master) and the ALU under test (slave).
interface alu_bist_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [5:0]       alu_fn;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_v;
  logic             alu_n;

  modport master (
    output alu_a, alu_b, alu_fn,
    input  alu_out, alu_z, alu_v, alu_n
  );

  modport slave (
    input  alu_a, alu_b, alu_fn,
    output alu_out, alu_z, alu_v, alu_n
  );
endinterface

// File: rtl/alu_bist_seq.sv
// alu_bist_seq: built-in self-test sequencer for the 16-bit ALU.
// Walks a fixed table of operation vectors, drives registered operands and
// function code, waits SETTLE cycles, then compares result and (optionally)
// the z/v/n flags. Reports busy/done/pass, an error count and the first
// failing vector index.
// Optional build macro ALU_BIST_HALT_ON_FAIL_EN: when defined, the first
// mismatch ends the run immediately; otherwise every vector always runs.
module alu_bist_seq #(
  parameter int WIDTH   = 16,
  parameter int NUM_VEC = 8,
  parameter int SETTLE  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  alu_bist_seq_if.master alu,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     err_count,
  output logic [7:0]     fail_idx
);

  localparam int IDX_W = 4;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Stimulus half of a table entry
  typedef struct packed {
    logic [5:0]  fn;
    logic [15:0] a;
    logic [15:0] b;
  } ops_t;

  // Expected-response half of a table entry
  typedef struct packed {
    logic [15:0] out;
    logic        chk;
    logic [2:0]  zvn;
  } exp_t;

  function automatic ops_t vec_ops(input logic [IDX_W-1:0] i);
    ops_t o;
    case (i)
      4'd0:    o = '{fn: 6'h00, a: 16'h0101, b: 16'h0011};
      4'd1:    o = '{fn: 6'h00, a: 16'h7FFF, b: 16'h7FFF};
      4'd2:    o = '{fn: 6'h01, a: 16'h0000, b: 16'h0101};
      4'd3:    o = '{fn: 6'h18, a: 16'h1234, b: 16'hEDCB};
      4'd4:    o = '{fn: 6'h16, a: 16'hABCD, b: 16'hABCD};
      4'd5:    o = '{fn: 6'h20, a: 16'h0871, b: 16'h0007};
      4'd6:    o = '{fn: 6'h23, a: 16'hFFFF, b: 16'h0007};
      4'd7:    o = '{fn: 6'h35, a: 16'h0871, b: 16'h0A71};
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic exp_t vec_exp(input logic [IDX_W-1:0] i);
    exp_t e;
    case (i)
      4'd0:    e = '{out: 16'h0112, chk: 1'b1, zvn: 3'b000};
      4'd1:    e = '{out: 16'hFFFE, chk: 1'b1, zvn: 3'b011};
      4'd2:    e = '{out: 16'hFEFF, chk: 1'b1, zvn: 3'b001};
      4'd3:    e = '{out: 16'h0000, chk: 1'b0, zvn: 3'b000};
      4'd4:    e = '{out: 16'h0000, chk: 1'b0, zvn: 3'b000};
      4'd5:    e = '{out: 16'h3880, chk: 1'b0, zvn: 3'b000};
      4'd6:    e = '{out: 16'hFFFF, chk: 1'b0, zvn: 3'b000};
      4'd7:    e = '{out: 16'h0001, chk: 1'b0, zvn: 3'b000};
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       fn_q, fn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       fail_q, fail_d;

  ops_t             ld_ops;
  exp_t             chk_exp;
  logic             mismatch;
  logic             halt;
  logic [7:0]       err_inc;

  // Next-state, table lookup and compare logic for the sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    halt    = 1'b0;

    ld_ops   = vec_ops((state_q == ST_CHECK) ? idx_q + 1'b1 : '0);
    chk_exp  = vec_exp(idx_q);
    mismatch = (alu.alu_out != WIDTH'(chk_exp.out)) ||
               (chk_exp.chk && ({alu.alu_z, alu.alu_v, alu.alu_n} != chk_exp.zvn));
    err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
          a_d     = WIDTH'(ld_ops.a);
          b_d     = WIDTH'(ld_ops.b);
          fn_d    = ld_ops.fn;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 8'd0;
          fail_d  = 8'd0;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          if (err_q == 8'd0) begin
            fail_d = 8'(idx_q);
          end
        end
`ifdef ALU_BIST_HALT_ON_FAIL_EN
        halt = mismatch;
`else
        halt = 1'b0;
`endif
        if (halt || (idx_q >= IDX_LAST)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d = ST_WAIT;
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          a_d     = WIDTH'(ld_ops.a);
          b_d     = WIDTH'(ld_ops.b);
          fn_d    = ld_ops.fn;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      fail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign alu.alu_a  = a_q;
  assign alu.alu_b  = b_q;
  assign alu.alu_fn = fn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_idx   = fail_q;

endmodule

// File: tb/tb_alu_bist_seq.sv
// tb_alu_bist_seq: self-checking bench for alu_bist_seq. A behavioural ALU
// (with injectable faults) answers the sequencer; the expected outcome of
// each run is predicted from the vector table and the ALU model.
module tb_alu_bist_seq;

  localparam int W   = 16;
  localparam int NV  = 8;
  localparam int ST  = 2;
  localparam int NV2 = 3;
  localparam int ST2 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_idx;
  logic       busy2, done2, pass2;
  logic [7:0] err_count2, fail_idx2;

  int n_checks = 0;
  int n_fail   = 0;

  // Fault injection knobs for the main ALU model
  logic        fault_on   = 1'b0;
  int          fault_vec  = 0;
  logic [15:0] out_mask   = '0;
  logic [2:0]  flag_mask  = '0;
  logic        v_stuck0   = 1'b0;

  typedef struct packed {
    logic [5:0]  fn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic        chk;
    logic [2:0]  zvn;
  } entry_t;

  alu_bist_seq_if #(.WIDTH(W)) bus ();
  alu_bist_seq_if #(.WIDTH(W)) bus2 ();

  alu_bist_seq #(.WIDTH(W), .NUM_VEC(NV), .SETTLE(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_idx  (fail_idx)
  );

  alu_bist_seq #(.WIDTH(W), .NUM_VEC(NV2), .SETTLE(ST2)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .alu       (bus2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err_count2),
    .fail_idx  (fail_idx2)
  );

  always #5 clk = ~clk;

  // Reference vector table
  function automatic entry_t spec_entry(input int i);
    entry_t e;
    case (i)
      0:       e = '{6'h00, 16'h0101, 16'h0011, 16'h0112, 1'b1, 3'b000};
      1:       e = '{6'h00, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b1, 3'b011};
      2:       e = '{6'h01, 16'h0000, 16'h0101, 16'hFEFF, 1'b1, 3'b001};
      3:       e = '{6'h18, 16'h1234, 16'hEDCB, 16'h0000, 1'b0, 3'b000};
      4:       e = '{6'h16, 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 3'b000};
      5:       e = '{6'h20, 16'h0871, 16'h0007, 16'h3880, 1'b0, 3'b000};
      6:       e = '{6'h23, 16'hFFFF, 16'h0007, 16'hFFFF, 1'b0, 3'b000};
      7:       e = '{6'h35, 16'h0871, 16'h0A71, 16'h0001, 1'b0, 3'b000};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Behavioural ALU: returns {out, z, v, n}
  function automatic logic [18:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] fn);
    logic [15:0] sum, res;
    logic        v;
    sum = fn[0] ? a - b : a + b;
    v   = fn[0] ? ((a[15] != b[15]) && (sum[15] != a[15]))
                : ((a[15] == b[15]) && (sum[15] != a[15]));
    case (fn)
      6'h00, 6'h01: res = sum;
      6'h18:        res = a & b;
      6'h1E:        res = a | b;
      6'h16:        res = a ^ b;
      6'h1A:        res = a;
      6'h20:        res = a << b[3:0];
      6'h21:        res = a >> b[3:0];
      6'h23:        res = $signed(a) >>> b[3:0];
      6'h33:        res = {15'd0, a == b};
      6'h35:        res = {15'd0, $signed(a) < $signed(b)};
      6'h37:        res = {15'd0, $signed(a) <= $signed(b)};
      default:      res = 16'h0000;
    endcase
    return {res, (sum == 16'h0000), v, sum[15]};
  endfunction

  function automatic logic [18:0] faulty(input logic [18:0] r, input logic hit);
    logic [18:0] f;
    f = r;
    if (fault_on && hit) f = f ^ {out_mask, flag_mask};
    if (v_stuck0) f[1] = 1'b0;
    return f;
  endfunction

  logic [18:0] alu_r;
  entry_t      fault_e;

  // Main ALU model, possibly faulted, answering the main sequencer
  always_comb begin
    fault_e = spec_entry(fault_vec);
    alu_r   = faulty(alu_ref(bus.alu_a, bus.alu_b, bus.alu_fn),
                     (bus.alu_fn == fault_e.fn) && (bus.alu_a == fault_e.a) &&
                     (bus.alu_b == fault_e.b));
  end

  assign bus.alu_out = alu_r[18:3];
  assign bus.alu_z   = alu_r[2];
  assign bus.alu_v   = alu_r[1];
  assign bus.alu_n   = alu_r[0];

  logic [18:0] alu_r2;
  assign alu_r2       = alu_ref(bus2.alu_a, bus2.alu_b, bus2.alu_fn);
  assign bus2.alu_out = alu_r2[18:3];
  assign bus2.alu_z   = alu_r2[2];
  assign bus2.alu_v   = alu_r2[1];
  assign bus2.alu_n   = alu_r2[0];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict outcome of a run from the table and the (faulted) ALU model
  task automatic predict(input int nvec, input int settle, output int e_err,
                         output int e_first, output int e_done, output int e_last);
    entry_t      e;
    logic [18:0] r;
    e_err   = 0;
    e_first = 0;
    e_last  = nvec - 1;
    for (int i = 0; i < nvec; i++) begin
      e = spec_entry(i);
      r = faulty(alu_ref(e.a, e.b, e.fn), i == fault_vec);
      if ((r[18:3] != e.exp_out) || (e.chk && (r[2:0] != e.zvn))) begin
        if (e_err == 0) e_first = i;
        e_err++;
`ifdef ALU_BIST_HALT_ON_FAIL_EN
        e_last = i;
        break;
`endif
      end
    end
    e_done = (e_last + 1) * (settle + 1);
  endtask

  task automatic check_ops(input string tag, input int vi);
    entry_t e;
    e = spec_entry(vi);
    checkOutput({tag, ".a"},  bus.alu_a,  e.a);
    checkOutput({tag, ".b"},  bus.alu_b,  e.b);
    checkOutput({tag, ".fn"}, bus.alu_fn, e.fn);
  endtask

  // One run of the main sequencer; optional spurious starts and mid-run reset
  task automatic applyStimulus(input int gap, input bit spurious, input int abort_at);
    int e_err, e_first, e_done, e_last;
    predict(NV, ST, e_err, e_first, e_done, e_last);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j <= e_done; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.pass", pass, 0);
        checkOutput("rst.err",  err_count, 0);
        checkOutput("rst.fidx", fail_idx, 0);
        checkOutput("rst.a",    bus.alu_a, 0);
        checkOutput("rst.b",    bus.alu_b, 0);
        checkOutput("rst.fn",   bus.alu_fn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (j < e_done) begin
        checkOutput("run.busy", busy, 1);
        checkOutput("run.done", done, 0);
        checkOutput("run.pass", pass, 0);
        check_ops("run.op", j / (ST + 1));
      end else begin
        checkOutput("end.busy", busy, 0);
        checkOutput("end.done", done, 1);
        checkOutput("end.pass", pass, e_err == 0);
        checkOutput("end.err",  err_count, e_err);
        if (e_err != 0) checkOutput("end.fidx", fail_idx, e_first);
        check_ops("end.op", e_last);
      end
      start = spurious && ((j == 4) || (j == 9));
    end
    start = 1'b0;
  endtask

  // One run of the short-table instance
  task automatic runSmall();
    int e_err, e_first, e_done, e_last;
    entry_t e;
    fault_on = 1'b0;
    v_stuck0 = 1'b0;
    predict(NV2, ST2, e_err, e_first, e_done, e_last);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int j = 0; j <= e_done; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      e = spec_entry((j < e_done) ? j / (ST2 + 1) : e_last);
      checkOutput("sm.a",    bus2.alu_a, e.a);
      checkOutput("sm.fn",   bus2.alu_fn, e.fn);
      checkOutput("sm.busy", busy2, j < e_done);
      checkOutput("sm.done", done2, j >= e_done);
    end
    checkOutput("sm.pass", pass2, 1);
    checkOutput("sm.err",  err_count2, 0);
  endtask

  task automatic set_fault(input bit on, input int vec, input logic [15:0] om,
                           input logic [2:0] fm, input bit vs);
    fault_on  = on;
    fault_vec = vec;
    out_mask  = om;
    flag_mask = fm;
    v_stuck0  = vs;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.pass", pass, 0);
    checkOutput("reset.err",  err_count, 0);
    checkOutput("reset.fidx", fail_idx, 0);
    checkOutput("reset.a",    bus.alu_a, 0);
    checkOutput("reset.fn",   bus.alu_fn, 0);
    checkOutput("reset.done2", done2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_fault(1'b0, 0, 16'h0000, 3'b000, 1'b0);
    applyStimulus(1, 1'b0, -1);
    set_fault(1'b1, 5, 16'h0001, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, -1);
    set_fault(1'b0, 0, 16'h0000, 3'b000, 1'b1);
    applyStimulus(2, 1'b0, -1);
    set_fault(1'b0, 0, 16'h0000, 3'b000, 1'b0);
    applyStimulus(0, 1'b1, -1);
    applyStimulus(1, 1'b0, 12);
    applyStimulus(1, 1'b0, -1);
    runSmall();

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 2))
        0: set_fault(1'b0, 0, 16'h0000, 3'b000, 1'b0);
        1: set_fault(1'b1, $urandom_range(0, NV - 1), 16'($urandom_range(1, 16'hFFFF)),
                     3'b000, 1'b0);
        default: set_fault(1'b1, $urandom_range(0, NV - 1), 16'h0000,
                           3'($urandom_range(1, 7)), 1'b0);
      endcase
      applyStimulus($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
